restoring_divider_seq: RTL and testbench



---
 rtl/div_pkg.sv | 16 +
 rtl/restoring_divider_seq_substep.sv | 25 ++
 rtl/restoring_divider_seq.sv | 133 +++++++++++++
 tb/tb_restoring_divider_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states and
// the iteration counter width helper.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Counter must be able to hold the value N.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/restoring_divider_seq_substep.sv
// One restoring shift/subtract step on unsigned magnitudes: shift {A,Q}
// left one bit, try A-B, keep the difference only when it does not borrow.
module restoring_substep #(
  parameter int N = 8
) (
  input  logic [N:0]   a,
  input  logic [N-1:0] q,
  input  logic [N:0]   b,
  output logic [N:0]   next_a,
  output logic [N-1:0] next_q
);

  logic [N+1:0] shifted;
  logic [N+1:0] diff;
  logic         ge;

  always_comb begin
    shifted = {a, q[N-1]};
    diff    = shifted - {1'b0, b};
    ge      = (shifted >= {1'b0, b});
    next_a  = ge ? (N+1)'(diff) : (N+1)'(shifted);
    next_q  = {q[N-2:0], ge};
  end

endmodule

// File: rtl/restoring_divider_seq.sv
// Sequential signed divider: sign/magnitude split, N restoring substeps,
// then a fix-up cycle applying signs and the zero/overflow overrides.
module restoring_divider_seq
  import div_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int CW = count_width(N);
  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  state_t state, state_next;

  logic [CW-1:0] count;
  logic [N:0]    a_reg;
  logic [N-1:0]  q_reg;
  logic [N:0]    b_reg;
  logic [N:0]    a_next;
  logic [N-1:0]  q_next;
  logic [N-1:0]  dividend_reg;
  logic          neg_quo;
  logic          neg_rem;
  logic          zero_div;
  logic          ovf;

  logic [N:0]    dividend_ext;
  logic [N:0]    divisor_ext;
  logic [N:0]    dividend_abs;
  logic [N:0]    divisor_abs;

  always_comb begin
    dividend_ext = {dividend[N-1], dividend};
    divisor_ext  = {divisor[N-1], divisor};
    dividend_abs = dividend[N-1] ? -dividend_ext : dividend_ext;
    divisor_abs  = divisor[N-1]  ? -divisor_ext  : divisor_ext;
  end

  restoring_substep #(.N(N)) u_substep (
    .a      (a_reg),
    .q      (q_reg),
    .b      (b_reg),
    .next_a (a_next),
    .next_q (q_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ITER;
      ITER:    if (count == CW'(N - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= '0;
      a_reg        <= '0;
      q_reg        <= '0;
      b_reg        <= '0;
      dividend_reg <= '0;
      neg_quo      <= 1'b0;
      neg_rem      <= 1'b0;
      zero_div     <= 1'b0;
      ovf          <= 1'b0;
      done         <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      div_by_zero  <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dividend_reg <= dividend;
            neg_rem      <= dividend[N-1];
            neg_quo      <= dividend[N-1] ^ divisor[N-1];
            zero_div     <= (divisor == '0);
            ovf          <= (dividend == MOST_NEG) && (divisor == '1);
            // |dividend| <= 2^(N-1) always fits N unsigned bits
            q_reg        <= N'(dividend_abs);
            b_reg        <= divisor_abs;
            a_reg        <= '0;
            count        <= '0;
          end
        end
        ITER: begin
          a_reg <= a_next;
          q_reg <= q_next;
          count <= count + 1'b1;
        end
        FIX: begin
          done        <= 1'b1;
          div_by_zero <= zero_div;
          overflow    <= ovf && !zero_div;
          if (zero_div) begin
            quotient  <= '1;
            remainder <= dividend_reg;
          end else if (ovf) begin
            quotient  <= MOST_NEG;
            remainder <= '0;
          end else begin
            quotient  <= neg_quo ? -q_reg : q_reg;
            remainder <= neg_rem ? N'(-a_reg) : N'(a_reg);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider_seq.sv
// Randomised and directed check of restoring_divider_seq against plain
// signed-integer division, including latency, handshake and reset abort.
module tb_restoring_divider_seq;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  int total = 0;
  int bad = 0;

  restoring_divider_seq #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic void ref_div(input int x, input int y,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic dz, output logic ov);
    int qi, ri;
    dz = 1'b0;
    ov = 1'b0;
    if (y == 0) begin
      qi = -1;
      ri = x;
      dz = 1'b1;
    end else if (x == -128 && y == -1) begin
      qi = -128;
      ri = 0;
      ov = 1'b1;
    end else begin
      qi = x / y;
      ri = x % y;
    end
    q = 8'(qi);
    r = 8'(ri);
  endfunction

  // Called at a negedge with the DUT idle (or in its done cycle); returns at
  // the negedge of the done cycle with start low.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input bit hold);
    logic [7:0] eq, er;
    logic       edz, eov;
    int         cyc;
    ref_div(int'($signed(x)), int'($signed(y)), eq, er, edz, eov);
    start    = 1'b1;
    dividend = x;
    divisor  = y;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      if (cyc == 1) check("busy_after_accept", 32'(busy), 32'd1);
      if (cyc == N + 1) check("busy_before_fix", 32'(busy), 32'd1);
    end while (!done && cyc < 40);
    start = 1'b0;
    if (!done) check("done_timeout", 32'(cyc), 32'(N + 2));
    check("latency", 32'(cyc - 1), 32'(N + 1));
    check("busy_in_done", 32'(busy), 32'd0);
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("div_by_zero", 32'(div_by_zero), 32'(edz));
    check("overflow", 32'(overflow), 32'(eov));
  endtask

  task automatic check_idle_hold(input logic [7:0] q, input logic [7:0] r);
    @(negedge clk);
    check("done_single_pulse", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("hold_quotient", 32'(quotient), 32'(q));
    check("hold_remainder", 32'(remainder), 32'(r));
  endtask

  initial begin
    int dones;
    logic [7:0] x, y;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back: each call starts in the previous done cycle.
    run_op(8'd100, 8'd7, 1'b0);
    run_op(-8'sd100, 8'd7, 1'b0);
    run_op(8'd100, -8'sd7, 1'b0);
    run_op(-8'sd100, -8'sd7, 1'b0);
    run_op(8'h80, 8'hFF, 1'b0);
    run_op(8'h80, 8'd1, 1'b0);
    run_op(8'd37, 8'd0, 1'b0);
    run_op(8'd0, 8'd5, 1'b0);
    run_op(8'h80, 8'd0, 1'b0);
    run_op(8'd127, 8'h80, 1'b0);
    check_idle_hold(8'd0, 8'd127);

    // Start held high with changing operands: only the first op counts.
    run_op(8'd77, 8'd9, 1'b1);
    check_idle_hold(8'd8, 8'd5);

    // Reset on the fourth ITER cycle aborts without a done pulse.
    start = 1'b1;
    dividend = 8'd55;
    divisor = 8'd3;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_dz", 32'(div_by_zero), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    dones = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      if (done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    run_op(8'd127, 8'd2, 1'b0);

    for (int i = 0; i < 40; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      case ($urandom_range(0, 7))
        0: y = 8'd0;
        1: x = 8'h80;
        2: y = 8'hFF;
        default: ;
      endcase
      run_op(x, y, 1'b0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", total, -1);
    $fatal(1, "timeout");
  end

endmodule
